// File: rtl/cpu_pkg.sv
// Shared encodings for the ARM-subset pipeline: instruction classes, DP opcodes, condition codes.
// Also holds the decoded-field bundle and the immediate-rotation helper used by decode.
package cpu_pkg;

  typedef enum logic [1:0] {
    CLS_DP     = 2'd0,
    CLS_LDST   = 2'd1,
    CLS_BRANCH = 2'd2,
    CLS_UNDEF  = 2'd3
  } instr_class_e;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  localparam logic [3:0] REG_LR = 4'd14;
  localparam logic [3:0] REG_PC = 4'd15;

  typedef struct packed {
    logic [31:0]  pc;
    logic [3:0]   cond;
    instr_class_e cls;
    logic [3:0]   opcode;
    logic         s;
    logic         imm_sel;
    logic [31:0]  imm;
    logic [6:0]   shift;
    logic         load;
    logic         up;
    logic         wr_en;
    logic [3:0]   rd;
  } dec_t;

  // DP immediate: imm8 zero-extended then rotated right by twice the 4-bit rotate field.
  function automatic logic [31:0] ror_imm(input logic [7:0] imm8, input logic [3:0] rot);
    logic [31:0] base;
    logic [63:0] dbl;
    base = {24'b0, imm8};
    dbl  = {base, base} >> {rot, 1'b0};
    return dbl[31:0];
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Busy-register scoreboard: set on issue, clear on writeback (set wins), hazard query is combinational on registered state.
// No latency of its own; a release becomes visible to the query the cycle after wb, and it never applies backpressure itself.
module decode_scoreboard
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        set_vld,
  input  logic [3:0]  set_addr,
  input  logic        clr_vld,
  input  logic [3:0]  clr_addr,
  input  logic        r1_vld,
  input  logic [3:0]  r1_addr,
  input  logic        r2_vld,
  input  logic [3:0]  r2_addr,
  input  logic        rd_vld,
  input  logic [3:0]  rd_addr,
  output logic        hazard,
  output logic [15:0] busy
);

  logic [15:0] busy_q;
  logic [15:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_vld) busy_d[clr_addr] = 1'b0;
    if (set_vld && set_addr != REG_PC) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  // Only registered state is consulted: register_file returns pre-write data in the wb cycle.
  always_comb begin
    hazard = 1'b0;
    if (r1_vld && r1_addr != REG_PC && busy_q[r1_addr]) hazard = 1'b1;
    if (r2_vld && r2_addr != REG_PC && busy_q[r2_addr]) hazard = 1'b1;
    if (rd_vld && rd_addr != REG_PC && busy_q[rd_addr]) hazard = 1'b1;
  end

  assign busy = busy_q;

endmodule

// File: rtl/decode_stage.sv
// ARM-subset decode: read addresses combinational from instr_i, decoded fields registered for execute.
// Latency 1 cycle; ready_o drops on RAW/WAW scoreboard hazard or flush, holding fetch with a bubble downstream.
module decode_stage
  import cpu_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] instr_i,
  input  logic        instr_valid_i,
  input  logic [31:0] pc_i,
  output logic        ready_o,
  input  logic        flush_i,
  input  logic        wb_valid_i,
  input  logic [3:0]  wb_addr_i,
  output logic [3:0]  r1_addr_o,
  output logic [3:0]  r2_addr_o,
  output logic        valid_o,
  output logic [31:0] pc_o,
  output logic [3:0]  cond_o,
  output logic [1:0]  class_o,
  output logic [3:0]  opcode_o,
  output logic        s_o,
  output logic        imm_sel_o,
  output logic [31:0] imm_o,
  output logic [6:0]  shift_o,
  output logic        load_o,
  output logic        up_o,
  output logic        wr_en_o,
  output logic [3:0]  rd_o
);

  dec_t       dec;
  dec_t       dec_q;
  logic       valid_q;
  logic       r1_used;
  logic       r2_used;
  logic [3:0] r1_addr;
  logic [3:0] r2_addr;
  logic       hazard;
  logic       accept;
  logic [15:0] busy;
  logic       unused_bits;

  assign unused_bits = instr_i[4];

  always_comb begin
    dec        = '0;
    dec.pc     = pc_i;
    dec.cond   = instr_i[31:28];
    dec.cls    = CLS_UNDEF;
    r1_used    = 1'b0;
    r2_used    = 1'b0;
    r1_addr    = 4'd0;
    r2_addr    = 4'd0;
    if (instr_i[27:26] == 2'b00) begin
      dec.cls     = CLS_DP;
      dec.opcode  = instr_i[24:21];
      dec.s       = instr_i[20];
      dec.imm_sel = instr_i[25];
      dec.rd      = instr_i[15:12];
      dec.wr_en   = (instr_i[24:23] != 2'b10);
      r1_used     = !(instr_i[24:21] == OP_MOV || instr_i[24:21] == OP_MVN);
      r1_addr     = r1_used ? instr_i[19:16] : 4'd0;
      if (instr_i[25]) begin
        dec.imm = ror_imm(instr_i[7:0], instr_i[11:8]);
      end else begin
        dec.shift = {instr_i[11:7], instr_i[6:5]};
        r2_used   = 1'b1;
        r2_addr   = instr_i[3:0];
      end
    end else if (instr_i[27:26] == 2'b01) begin
      dec.cls     = CLS_LDST;
      dec.imm_sel = 1'b1;
      dec.imm     = {20'b0, instr_i[11:0]};
      dec.load    = instr_i[20];
      dec.up      = instr_i[23];
      dec.wr_en   = instr_i[20];
      dec.rd      = instr_i[15:12];
      r1_used     = 1'b1;
      r1_addr     = instr_i[19:16];
      // Stores read the data register through the second port.
      r2_used     = !instr_i[20];
      r2_addr     = instr_i[20] ? 4'd0 : instr_i[15:12];
    end else if (instr_i[27:25] == 3'b101) begin
      dec.cls     = CLS_BRANCH;
      dec.imm_sel = 1'b1;
      dec.imm     = {{6{instr_i[23]}}, instr_i[23:0], 2'b00};
      dec.wr_en   = instr_i[24];
      dec.rd      = REG_LR;
    end
  end

  decode_scoreboard u_sb (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .set_vld  (accept && dec.wr_en),
    .set_addr (dec.rd),
    .clr_vld  (wb_valid_i),
    .clr_addr (wb_addr_i),
    .r1_vld   (r1_used),
    .r1_addr  (r1_addr),
    .r2_vld   (r2_used),
    .r2_addr  (r2_addr),
    .rd_vld   (dec.wr_en),
    .rd_addr  (dec.rd),
    .hazard   (hazard),
    .busy     (busy)
  );

  assign ready_o   = ~(instr_valid_i & hazard) & ~flush_i;
  assign accept    = instr_valid_i & ready_o;
  assign r1_addr_o = r1_addr;
  assign r2_addr_o = r2_addr;

  // Bubbles also drop wr_en so execute never sees a stale writer.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      dec_q   <= dec;
    end else begin
      valid_q     <= 1'b0;
      dec_q.wr_en <= 1'b0;
    end
  end

  assign valid_o   = valid_q;
  assign pc_o      = dec_q.pc;
  assign cond_o    = dec_q.cond;
  assign class_o   = dec_q.cls;
  assign opcode_o  = dec_q.opcode;
  assign s_o       = dec_q.s;
  assign imm_sel_o = dec_q.imm_sel;
  assign imm_o     = dec_q.imm;
  assign shift_o   = dec_q.shift;
  assign load_o    = dec_q.load;
  assign up_o      = dec_q.up;
  assign wr_en_o   = dec_q.wr_en;
  assign rd_o      = dec_q.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decoded fields, scoreboard stalls, flush and reset behaviour.
module tb_decode_stage;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] instr_i;
  logic        instr_valid_i;
  logic [31:0] pc_i;
  logic        ready_o;
  logic        flush_i;
  logic        wb_valid_i;
  logic [3:0]  wb_addr_i;
  logic [3:0]  r1_addr_o;
  logic [3:0]  r2_addr_o;
  logic        valid_o;
  logic [31:0] pc_o;
  logic [3:0]  cond_o;
  logic [1:0]  class_o;
  logic [3:0]  opcode_o;
  logic        s_o;
  logic        imm_sel_o;
  logic [31:0] imm_o;
  logic [6:0]  shift_o;
  logic        load_o;
  logic        up_o;
  logic        wr_en_o;
  logic [3:0]  rd_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  decode_stage dut (
    .clk_i(clk_i), .reset_i(reset_i), .instr_i(instr_i), .instr_valid_i(instr_valid_i),
    .pc_i(pc_i), .ready_o(ready_o), .flush_i(flush_i), .wb_valid_i(wb_valid_i),
    .wb_addr_i(wb_addr_i), .r1_addr_o(r1_addr_o), .r2_addr_o(r2_addr_o), .valid_o(valid_o),
    .pc_o(pc_o), .cond_o(cond_o), .class_o(class_o), .opcode_o(opcode_o), .s_o(s_o),
    .imm_sel_o(imm_sel_o), .imm_o(imm_o), .shift_o(shift_o), .load_o(load_o), .up_o(up_o),
    .wr_en_o(wr_en_o), .rd_o(rd_o)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, comb checks 2ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic vld, input logic [31:0] pc,
                       input logic fl, input logic wbv, input logic [3:0] wba);
    instr_i = ins; instr_valid_i = vld; pc_i = pc; flush_i = fl;
    wb_valid_i = wbv; wb_addr_i = wba;
    #2;
  endtask

  initial begin
    reset_i = 1'b1;
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
    tick(); tick();
    check("rst_valid", {31'b0, valid_o}, 32'd0);
    check("rst_wr_en", {31'b0, wr_en_o}, 32'd0);
    check("rst_imm", imm_o, 32'd0);
    check("rst_busy", {16'b0, dut.u_sb.busy}, 32'd0);
    reset_i = 1'b0;

    // MOV r1,#5
    drive(32'hE3A01005, 1'b1, 32'h100, 1'b0, 1'b0, 4'd0);
    check("mov_r1addr", {28'b0, r1_addr_o}, 32'd0);
    check("mov_ready", {31'b0, ready_o}, 32'd1);
    tick();
    check("mov_valid", {31'b0, valid_o}, 32'd1);
    check("mov_wr_en", {31'b0, wr_en_o}, 32'd1);
    check("mov_rd", {28'b0, rd_o}, 32'd1);
    check("mov_imm", imm_o, 32'd5);
    check("mov_opcode", {28'b0, opcode_o}, 32'hD);
    check("mov_pc", pc_o, 32'h100);
    check("mov_cond", {28'b0, cond_o}, 32'hE);
    check("mov_busy", {16'b0, dut.u_sb.busy}, 32'h0002);

    // ADD r2,r1,r1 stalls on busy r1
    drive(32'hE0812001, 1'b1, 32'h104, 1'b0, 1'b0, 4'd0);
    check("add_r1addr", {28'b0, r1_addr_o}, 32'd1);
    check("add_r2addr", {28'b0, r2_addr_o}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("add_stall_ready", {31'b0, ready_o}, 32'd0);
      tick();
      #2;
    end
    check("add_bubble_valid", {31'b0, valid_o}, 32'd0);
    // Writeback of r1 in cycle K: still stalled in K
    drive(32'hE0812001, 1'b1, 32'h104, 1'b0, 1'b1, 4'd1);
    check("add_wb_cycle_ready", {31'b0, ready_o}, 32'd0);
    tick();
    drive(32'hE0812001, 1'b1, 32'h104, 1'b0, 1'b0, 4'd0);
    check("add_after_wb_ready", {31'b0, ready_o}, 32'd1);
    tick();
    check("add_valid", {31'b0, valid_o}, 32'd1);
    check("add_rd", {28'b0, rd_o}, 32'd2);
    check("add_opcode", {28'b0, opcode_o}, 32'h4);
    check("add_imm_sel", {31'b0, imm_sel_o}, 32'd0);
    check("add_class", {30'b0, class_o}, 32'd0);
    check("add_busy", {16'b0, dut.u_sb.busy}, 32'h0004);

    // MOV r0,#0xFF ror 8, while r2 retires
    drive(32'hE3A004FF, 1'b1, 32'h108, 1'b0, 1'b1, 4'd2);
    tick();
    check("rot_valid", {31'b0, valid_o}, 32'd1);
    check("rot_imm", imm_o, 32'hFF000000);
    check("rot_rd", {28'b0, rd_o}, 32'd0);
    check("rot_busy", {16'b0, dut.u_sb.busy}, 32'h0001);

    // BL -8, while r0 retires
    drive(32'hEBFFFFFE, 1'b1, 32'h10C, 1'b0, 1'b1, 4'd0);
    check("bl_r1addr", {28'b0, r1_addr_o}, 32'd0);
    tick();
    check("bl_imm", imm_o, 32'hFFFFFFF8);
    check("bl_wr_en", {31'b0, wr_en_o}, 32'd1);
    check("bl_rd", {28'b0, rd_o}, 32'd14);
    check("bl_class", {30'b0, class_o}, 32'd2);
    check("bl_busy", {16'b0, dut.u_sb.busy}, 32'h4000);

    // MOV r3,#1 while lr retires, then STR r3,[r4,#8] stalls on r3
    drive(32'hE3A03001, 1'b1, 32'h110, 1'b0, 1'b1, 4'd14);
    tick();
    check("r3_busy", {16'b0, dut.u_sb.busy}, 32'h0008);
    drive(32'hE5843008, 1'b1, 32'h114, 1'b0, 1'b0, 4'd0);
    check("str_r1addr", {28'b0, r1_addr_o}, 32'd4);
    check("str_r2addr", {28'b0, r2_addr_o}, 32'd3);
    check("str_stall_ready", {31'b0, ready_o}, 32'd0);
    tick();
    drive(32'hE5843008, 1'b1, 32'h114, 1'b0, 1'b1, 4'd3);
    tick();
    drive(32'hE5843008, 1'b1, 32'h114, 1'b0, 1'b0, 4'd0);
    check("str_ready", {31'b0, ready_o}, 32'd1);
    tick();
    check("str_valid", {31'b0, valid_o}, 32'd1);
    check("str_wr_en", {31'b0, wr_en_o}, 32'd0);
    check("str_load", {31'b0, load_o}, 32'd0);
    check("str_up", {31'b0, up_o}, 32'd1);
    check("str_imm", imm_o, 32'd8);
    check("str_class", {30'b0, class_o}, 32'd1);
    check("str_busy", {16'b0, dut.u_sb.busy}, 32'h0000);

    // MOV r5,#1 accepted while a wb for r5 arrives: set wins
    drive(32'hE3A05001, 1'b1, 32'h118, 1'b0, 1'b1, 4'd5);
    tick();
    check("setclr_valid", {31'b0, valid_o}, 32'd1);
    check("setclr_busy", {16'b0, dut.u_sb.busy}, 32'h0020);

    // Flush with MOV r6 presented: not accepted, no busy change, registered op killed
    drive(32'hE3A06001, 1'b1, 32'h11C, 1'b1, 1'b0, 4'd0);
    check("flush_ready", {31'b0, ready_o}, 32'd0);
    tick();
    check("flush_valid", {31'b0, valid_o}, 32'd0);
    check("flush_wr_en", {31'b0, wr_en_o}, 32'd0);
    check("flush_busy", {16'b0, dut.u_sb.busy}, 32'h0020);

    // ADD r2,r5,r5 stalls; reset mid-stall clears everything
    drive(32'hE0852005, 1'b1, 32'h120, 1'b0, 1'b0, 4'd0);
    check("stall2_ready", {31'b0, ready_o}, 32'd0);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
    check("rst2_busy", {16'b0, dut.u_sb.busy}, 32'h0000);
    check("rst2_valid", {31'b0, valid_o}, 32'd0);
    check("rst2_ready", {31'b0, ready_o}, 32'd1);

    // MOV pc,#0 twice: R15 is never marked busy, so no WAW stall
    drive(32'hE3A0F000, 1'b1, 32'h0, 1'b0, 1'b0, 4'd0);
    tick();
    check("pc_rd", {28'b0, rd_o}, 32'd15);
    check("pc_busy", {16'b0, dut.u_sb.busy}, 32'h0000);
    drive(32'hE3A0F000, 1'b1, 32'h4, 1'b0, 1'b0, 4'd0);
    check("pc_again_ready", {31'b0, ready_o}, 32'd1);
    tick();
    drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 4'd0);
    check("pc_again_valid", {31'b0, valid_o}, 32'd1);
    check("pc_again_pc", pc_o, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
